dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory and peripheral subsystem for the single-cycle RISC-V core. It consumes the core's data port (word address, write data, read/write strobes) and returns read data in the same cycle. It holds a word-addressed data RAM, a GPIO register pair, and a prescaled compare timer that raises an interrupt request. It sits directly downstream of the core's load/store path.

## Interface
- RAM_AW, 9, RAM word-address width; RAM depth is 2**RAM_AW words (max 9).
- PRESC, 4, timer prescale; the counter advances once every PRESC enabled cycles (PRESC ≥ 1).
- GPIO_W, 16, width of the GPIO in/out ports.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- daddr  in  10  word address from the core.
- ddata_w  in  32  store data.
- d_w  in  1  write strobe, sampled at the CLK rising edge.
- d_r  in  1  read strobe.
- ddata_r  out  32  load data, combinational from daddr/d_r.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  registered outputs.
- irq  out  1  timer interrupt request, registered.

## Operation
- Decode: daddr[9]=0 selects the RAM at index daddr[RAM_AW-1:0]. daddr[9]=1 selects the peripheral register at daddr[3:0]. daddr[8:4] is ignored in the peripheral space.
- RAM: a write at the CLK edge when d_w=1. Reads are asynchronous. Contents are not reset.
- Peripheral registers:
  - 0 GPIO_OUT: RW; the low GPIO_W bits drive gpio_out.
  - 1 GPIO_IN: RO; value of the 2-flop synchronizer; upper bits read 0.
  - 2 TIMER_CNT: RW, 32 bits.
  - 3 TIMER_CMP: RW, 32 bits.
  - 4 TIMER_CTRL: RW bits[2:0]. bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN. Upper bits read 0.
  - 5 TIMER_STAT: bit0 MATCH. A write with ddata_w[0]=1 clears MATCH; a write with bit0=0 has no effect.
  - 6–15: read 0; writes ignored.
- ddata_r:
  - With d_r=1, ddata_r = selected word.
  - With d_r=0, ddata_r = 0.
  - If d_r=1 and d_w=1 in the same cycle, ddata_r returns the pre-write value and the write still occurs.
- Prescaler: a counter 0..PRESC-1. It advances only while EN=1. It resets to 0 when EN=0 or when TIMER_CNT is written. "tick" is asserted in the cycle where the prescaler = PRESC-1.
- Timer on tick:
  - If CNT == CMP: set MATCH. If AUTORELOAD=1, CNT←0; otherwise CNT←CNT+1.
  - If CNT != CMP: CNT←CNT+1, wrapping mod 2**32.
- irq is registered: irq ← MATCH_next & IRQ_EN.

## Timing
- Reset values: gpio_out=0, irq=0, CNT=0, CMP=0xFFFFFFFF, CTRL=0, MATCH=0, prescaler=0, synchronizer=0.
- ddata_r is combinational with zero latency, which the single-cycle core requires.
- Writes become visible on reads in the cycle after the CLK edge that performs the write.
- gpio_in reaches GPIO_IN 2 cycles after it settles.
- irq rises 1 cycle after the tick that sets MATCH (when IRQ_EN=1). It falls 1 cycle after the clearing write, or 1 cycle after IRQ_EN is cleared.
- Simultaneous events:
  - A software write to CNT on a tick edge wins over the increment/reload.
  - A MATCH set and a W1C clear on the same edge: the set wins, so MATCH stays 1.
  - A write to CMP on a tick edge: the comparison uses the old CMP.
- Reset asserted mid-operation: all registers take their reset values immediately (asynchronously). The RAM keeps its contents. ddata_r stays combinational.
- PRESC=1: tick is asserted every enabled cycle.

## Test plan
- RAM: write 0xDEADBEEF to daddr 0x005, then 0x12345678 to 0x1FF. Read back both values. Also read 0x005 with d_r=0 -> ddata_r=0.
- GPIO: write 0x0000A5A5 to daddr 0x200 -> gpio_out=0xA5A5 on the next cycle. Set gpio_in=0x3C3C -> a read of 0x201 returns 0x00003C3C from the 2nd cycle on.
- Timer one-shot: CMP=3, CTRL=0b101, PRESC=4 -> MATCH sets at the 16th enabled cycle, irq=1 one cycle later, CNT continues to 4. Writing 1 to 0x205 -> irq=0 the next cycle.
- Auto-reload: CMP=2, CTRL=0b111 -> CNT sequence 0,1,2,0,1,2. MATCH is set on every reload.
- Collisions: a CNT write of 0x100 coincident with a tick -> CNT=0x100. A W1C coincident with a match -> MATCH remains 1. Same-cycle d_r/d_w at a RAM address -> old data is returned.
- Reset mid-count: assert RSTn=0 while CNT=7 and irq=1 -> CNT=0, irq=0, gpio_out=0 with no clock edge. The RAM word written before reset reads back unchanged.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data RAM plus GPIO and a prescaled compare timer on the core's data port.
// Loads are combinational (zero latency); stores and register updates take effect at the CLK edge.
// No backpressure: every access completes in the cycle it is presented.
module dmem_mmio #(
    parameter int RAM_AW = 9,
    parameter int PRESC  = 4,
    parameter int GPIO_W = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [9:0]        daddr,
    input  logic [31:0]       ddata_w,
    input  logic              d_w,
    input  logic              d_r,
    output logic [31:0]       ddata_r,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    logic [31:0]       r_ram [2**RAM_AW];
    logic [31:0]       r_gpio_out;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic [2:0]        r_ctrl;
    logic              r_match;
    logic [PW-1:0]     r_presc;
    logic              r_irq;

    logic        w_per_sel;
    logic [3:0]  w_reg;
    logic        w_ram_we;
    logic        w_wr_gpo;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_cnt_nxt;
    logic        w_match_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [31:0] w_rd;

    assign w_per_sel = daddr[9];
    assign w_reg     = daddr[3:0];
    assign w_ram_we  = d_w & ~w_per_sel;
    assign w_wr_gpo  = d_w & w_per_sel & (w_reg == 4'd0);
    assign w_wr_cnt  = d_w & w_per_sel & (w_reg == 4'd2);
    assign w_wr_cmp  = d_w & w_per_sel & (w_reg == 4'd3);
    assign w_wr_ctrl = d_w & w_per_sel & (w_reg == 4'd4);
    assign w_wr_stat = d_w & w_per_sel & (w_reg == 4'd5);

    // RAM has no reset so its contents survive RSTn.
    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_ram[daddr[RAM_AW-1:0]] <= ddata_w;
        end
    end

    assign w_tick = r_ctrl[0] & (r_presc == PRESC_MAX);
    assign w_hit  = w_tick & (r_cnt == r_cmp);

    // Software writes override the timer; a match set overrides a same-edge clear.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_tick) begin
            w_cnt_nxt = (w_hit & r_ctrl[1]) ? 32'd0 : r_cnt + 32'd1;
        end
        if (w_wr_cnt) begin
            w_cnt_nxt = ddata_w;
        end

        w_match_nxt = r_match;
        if (w_wr_stat & ddata_w[0]) begin
            w_match_nxt = 1'b0;
        end
        if (w_hit) begin
            w_match_nxt = 1'b1;
        end

        w_presc_nxt = r_presc + PW'(1);
        if (~r_ctrl[0] | w_wr_cnt | (r_presc == PRESC_MAX)) begin
            w_presc_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cnt      <= '0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_ctrl     <= '0;
            r_match    <= 1'b0;
            r_presc    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_nxt;
            r_match <= w_match_nxt;
            r_presc <= w_presc_nxt;
            r_irq   <= w_match_nxt & r_ctrl[2];
            if (w_wr_gpo) begin
                r_gpio_out <= ddata_w;
            end
            if (w_wr_cmp) begin
                r_cmp <= ddata_w;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= ddata_w[2:0];
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (!w_per_sel) begin
            w_rd = r_ram[daddr[RAM_AW-1:0]];
        end else begin
            case (w_reg)
                4'd0:    w_rd = r_gpio_out;
                4'd1:    w_rd = 32'(r_sync2);
                4'd2:    w_rd = r_cnt;
                4'd3:    w_rd = r_cmp;
                4'd4:    w_rd = {29'd0, r_ctrl};
                4'd5:    w_rd = {31'd0, r_match};
                default: w_rd = '0;
            endcase
        end
    end

    assign ddata_r  = d_r ? w_rd : 32'd0;
    assign gpio_out = r_gpio_out[GPIO_W-1:0];
    assign irq      = r_irq;

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized and directed bench for dmem_mmio with a scoreboard against a behavioural model.
module tb_dmem_mmio;
    localparam int PRESC = 4;

    logic        CLK;
    logic        RSTn;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_w;
    logic        d_r;
    logic [31:0] ddata_r;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    dmem_mmio #(.RAM_AW(9), .PRESC(PRESC), .GPIO_W(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
        .ddata_r(ddata_r), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] rd;
        logic [15:0] go;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Behavioural reference model
    logic [31:0] m_ram [512];
    logic [31:0] m_gpo, m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_match, m_irq;
    logic [15:0] m_s1, m_s2;
    int          m_ps;
    logic [15:0] gin;

    task automatic m_reset();
        m_gpo = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0;
        m_match = 0; m_irq = 0; m_s1 = 0; m_s2 = 0; m_ps = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [9:0] a);
        if (!a[9]) return m_ram[a[8:0]];
        case (a[3:0])
            4'd0:    return m_gpo;
            4'd1:    return {16'd0, m_s2};
            4'd2:    return m_cnt;
            4'd3:    return m_cmp;
            4'd4:    return {29'd0, m_ctrl};
            4'd5:    return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_tick_now();
        return m_ctrl[0] && (m_ps == PRESC - 1);
    endfunction

    task automatic m_step(input logic [9:0] a, input logic [31:0] wd, input bit w, input logic [15:0] gi);
        bit tick, hit, wcnt, per;
        logic [31:0] ncnt;
        bit nmatch;
        per  = a[9];
        wcnt = w && per && (a[3:0] == 4'd2);
        tick = m_tick_now();
        hit  = tick && (m_cnt == m_cmp);
        ncnt = m_cnt;
        if (tick) ncnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (wcnt) ncnt = wd;
        nmatch = m_match;
        if (w && per && (a[3:0] == 4'd5) && wd[0]) nmatch = 0;
        if (hit) nmatch = 1;
        m_irq = nmatch && m_ctrl[2];
        m_ps  = (!m_ctrl[0] || wcnt) ? 0 : (m_ps + 1) % PRESC;
        if (w && per && a[3:0] == 4'd0) m_gpo = wd;
        if (w && per && a[3:0] == 4'd3) m_cmp = wd;
        if (w && per && a[3:0] == 4'd4) m_ctrl = wd[2:0];
        if (w && !per) m_ram[a[8:0]] = wd;
        m_cnt = ncnt; m_match = nmatch;
        m_s2 = m_s1; m_s1 = gi;
    endtask

    // One bus cycle: drive, record expectation, advance model, then move past the edge.
    task automatic cyc(input logic [9:0] a, input logic [31:0] wd, input bit w, input bit r);
        exp_t e;
        daddr = a; ddata_w = wd; d_w = w; d_r = r; gpio_in = gin;
        e.a = a; e.rd = r ? m_read(a) : 32'd0; e.go = m_gpo[15:0]; e.irq = m_irq;
        exp_q.push_back(e);
        m_step(a, wd, w, gin);
        @(posedge CLK); #1;
    endtask

    task automatic mid_reset();
        exp_t e;
        daddr = 10'h202; d_w = 0; d_r = 1; RSTn = 0;
        m_reset();
        #1;
        e.a = 10'h202; e.rd = m_read(10'h202); e.go = m_gpo[15:0]; e.irq = m_irq;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        RSTn = 1;
    endtask

    task automatic bound_fail(input string what);
        total++; bad++;
        $display("FAIL %s: bound expired before condition reached", what);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (ddata_r !== e.rd) begin
                    bad++;
                    $display("FAIL rdata a=%h got=%h exp=%h t=%0t", e.a, ddata_r, e.rd, $time);
                end
                total++;
                if (gpio_out !== e.go) begin
                    bad++;
                    $display("FAIL gpio_out got=%h exp=%h t=%0t", gpio_out, e.go, $time);
                end
                total++;
                if (irq !== e.irq) begin
                    bad++;
                    $display("FAIL irq got=%b exp=%b t=%0t", irq, e.irq, $time);
                end
            end
        end
    end

    initial begin
        bit ok;
        RSTn = 0; daddr = 0; ddata_w = 0; d_w = 0; d_r = 0; gin = 0; gpio_in = 0;
        m_reset();
        repeat (2) @(posedge CLK);
        #1 RSTn = 1;

        // Reset values
        cyc(10'h202, 0, 0, 1);
        cyc(10'h203, 0, 0, 1);
        cyc(10'h204, 0, 0, 1);
        cyc(10'h205, 0, 0, 1);

        // RAM
        cyc(10'h005, 32'hDEADBEEF, 1, 0);
        cyc(10'h1FF, 32'h12345678, 1, 0);
        cyc(10'h005, 0, 0, 1);
        cyc(10'h1FF, 0, 0, 1);
        cyc(10'h005, 0, 0, 0);

        // GPIO
        cyc(10'h200, 32'h0000A5A5, 1, 0);
        cyc(10'h200, 0, 0, 1);
        gin = 16'h3C3C;
        for (int i = 0; i < 4; i++) cyc(10'h3F1, 0, 0, 1);

        // One-shot timer
        cyc(10'h203, 32'd3, 1, 0);
        cyc(10'h204, 32'b101, 1, 0);
        for (int i = 0; i < 22; i++) cyc((i % 2) ? 10'h205 : 10'h202, 0, 0, 1);
        cyc(10'h205, 32'd1, 1, 0);
        cyc(10'h205, 0, 0, 1);
        cyc(10'h205, 0, 0, 1);

        // Auto-reload
        cyc(10'h204, 32'd0, 1, 0);
        cyc(10'h202, 32'd0, 1, 0);
        cyc(10'h203, 32'd2, 1, 0);
        cyc(10'h204, 32'b111, 1, 0);
        for (int i = 0; i < 30; i++) cyc((i % 3 == 2) ? 10'h205 : 10'h202, 0, 0, 1);

        // CNT write coincident with a tick
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_tick_now()) ok = 1; else cyc(10'h202, 0, 0, 1);
        end
        if (!ok) bound_fail("cnt_write_tick");
        cyc(10'h202, 32'h100, 1, 1);
        cyc(10'h202, 0, 0, 1);

        // W1C coincident with a match
        cyc(10'h202, 32'd0, 1, 0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_tick_now() && m_cnt == m_cmp) ok = 1; else cyc(10'h202, 0, 0, 1);
        end
        if (!ok) bound_fail("w1c_match");
        cyc(10'h205, 32'd1, 1, 0);
        cyc(10'h205, 0, 0, 1);

        // Same-cycle read/write at RAM
        cyc(10'h005, 32'h0BADF00D, 1, 1);
        cyc(10'h005, 0, 0, 1);

        // Reset mid-count with CNT=7 and irq=1
        cyc(10'h204, 32'd0, 1, 0);
        cyc(10'h202, 32'd0, 1, 0);
        cyc(10'h203, 32'd5, 1, 0);
        cyc(10'h205, 32'd1, 1, 0);
        cyc(10'h010, 32'hCAFEF00D, 1, 0);
        cyc(10'h204, 32'b101, 1, 0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (m_cnt == 32'd7 && m_irq) ok = 1; else cyc(10'h202, 0, 0, 1);
        end
        if (!ok) bound_fail("reach_cnt7");
        mid_reset();
        cyc(10'h010, 0, 0, 1);
        cyc(10'h202, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 16; i++) cyc(10'(i), $urandom, 1, 0);
        cyc(10'h203, 32'd4, 1, 0);
        cyc(10'h204, 32'b111, 1, 0);
        for (int i = 0; i < 500; i++) begin
            logic [9:0]  a;
            logic [31:0] wd;
            bit w, r;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3) a = {6'd0, 4'($urandom_range(0, 15))};
            else if (sel < 9) a = {1'b1, 5'($urandom), 4'($urandom_range(0, 5))};
            else a = {1'b1, 5'($urandom), 4'($urandom_range(6, 15))};
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) != 0);
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8));
            if (a[9] && a[3:0] == 4'd4 && w && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) gin = 16'($urandom);
            cyc(a, wd, w, r);
        end

        d_w = 0; d_r = 0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) bound_fail("scoreboard_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
